// File: rtl/expu_pkg.sv
// expu_pkg: shared types and format helpers for the exponential-unit blocks.
package expu_pkg;
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} acc_state_e;

    function automatic int fp_bias(fpnew_pkg::fp_format_e fmt);
        return (2 ** (fpnew_pkg::exp_bits(fmt) - 1)) - 1;
    endfunction
endpackage

// File: rtl/fpnew_pkg.sv
// fpnew_pkg: minimal format-description subset of the FPnew package so this slice builds standalone.
package fpnew_pkg;
    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4,
        FP8ALT  = 3'd5
    } fp_format_e;

    function automatic int exp_bits(fp_format_e fmt);
        case (fmt)
            FP32, FP16ALT: return 8;
            FP64:          return 11;
            FP16, FP8:     return 5;
            default:       return 4;
        endcase
    endfunction

    function automatic int man_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 23;
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 3;
        endcase
    endfunction

    function automatic int fp_width(fp_format_e fmt);
        return exp_bits(fmt) + man_bits(fmt) + 1;
    endfunction
endpackage

// File: rtl/expu_fp2fix.sv
// expu_fp2fix: combinational FP to unsigned fixed-point converter with saturation and error flags.
module expu_fp2fix
    import expu_pkg::*;
#(
    parameter fpnew_pkg::fp_format_e FPFORMAT = fpnew_pkg::FP16ALT,
    parameter int ACC_INT      = 8,
    parameter int ACC_FRACTION = 16,
    localparam int WIDTH     = fpnew_pkg::fp_width(FPFORMAT),
    localparam int ACC_WIDTH = ACC_INT + ACC_FRACTION
) (
    input  logic [WIDTH-1:0]     data_i,
    output logic [ACC_WIDTH-1:0] val_o,
    output logic                 sat_o,
    output logic                 err_o
);
    localparam int EXP_BITS = fpnew_pkg::exp_bits(FPFORMAT);
    localparam int MAN_BITS = fpnew_pkg::man_bits(FPFORMAT);
    localparam int BIAS     = fp_bias(FPFORMAT);
    localparam int MW       = MAN_BITS + 1;

    logic                sign;
    logic [EXP_BITS-1:0] exp_f;
    logic [MAN_BITS-1:0] man;
    logic [MW-1:0]       mag;
    int                  sh;

    assign {sign, exp_f, man} = data_i;
    assign mag = {1'b1, man};

    // sh is where the mantissa LSB lands relative to the accumulator LSB
    always_comb begin
        sh    = int'(exp_f) - BIAS + ACC_FRACTION - MAN_BITS;
        err_o = (&exp_f) || (sign && |exp_f);
        sat_o = !err_o && |exp_f && sh > ACC_WIDTH - MW;
        val_o = (err_o || exp_f == '0) ? '0 :
                sat_o                  ? '1 :
                (sh >= 0)              ? ACC_WIDTH'(mag) << sh :
                                         ACC_WIDTH'(mag >> (-sh));
    end
endmodule

// File: rtl/expu_accumulator.sv
// expu_accumulator: streaming row-sum accumulator for softmax denominators.
// Stage 1 converts FP to fixed point, stage 2 accumulates and hands off per row.
module expu_accumulator
    import expu_pkg::*;
#(
    parameter fpnew_pkg::fp_format_e FPFORMAT = fpnew_pkg::FP16ALT,
    parameter int ACC_INT      = 8,
    parameter int ACC_FRACTION = 16,
    parameter int CNT_WIDTH    = 16,
    localparam int WIDTH     = fpnew_pkg::fp_width(FPFORMAT),
    localparam int ACC_WIDTH = ACC_INT + ACC_FRACTION
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_data_i,
    input  logic                 in_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ACC_WIDTH-1:0] out_sum_o,
    output logic [CNT_WIDTH-1:0] out_count_o,
    output logic                 out_sat_o,
    output logic                 out_err_o
);
    acc_state_e           state_q, state_d;
    logic                 s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic                 s1_sat_q, s1_sat_d, s1_err_q, s1_err_d;
    logic [ACC_WIDTH-1:0] s1_val_q, s1_val_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, out_sum_q, out_sum_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, out_count_q, out_count_d;
    logic                 sat_q, sat_d, err_q, err_d;
    logic                 out_sat_q, out_sat_d, out_err_q, out_err_d;
    logic [ACC_WIDTH-1:0] conv_val, acc_n;
    logic [CNT_WIDTH-1:0] cnt_n;
    logic [ACC_WIDTH:0]   sum_ext;
    logic                 conv_sat, conv_err, hs_in, fin, sat_n, err_n;

    expu_fp2fix #(
        .FPFORMAT     (FPFORMAT),
        .ACC_INT      (ACC_INT),
        .ACC_FRACTION (ACC_FRACTION)
    ) u_fp2fix (
        .data_i (in_data_i),
        .val_o  (conv_val),
        .sat_o  (conv_sat),
        .err_o  (conv_err)
    );

    assign in_ready_o  = (state_q == ACCUM) && !(s1_valid_q && s1_last_q);
    assign out_valid_o = (state_q == HOLD);
    assign out_sum_o   = out_sum_q;
    assign out_count_o = out_count_q;
    assign out_sat_o   = out_sat_q;
    assign out_err_o   = out_err_q;

    always_comb begin
        hs_in       = in_valid_i && in_ready_o;
        s1_valid_d  = hs_in;
        s1_last_d   = hs_in ? in_last_i : s1_last_q;
        s1_val_d    = hs_in ? conv_val : s1_val_q;
        s1_sat_d    = hs_in ? conv_sat : s1_sat_q;
        s1_err_d    = hs_in ? conv_err : s1_err_q;
        sum_ext     = {1'b0, acc_q} + {1'b0, s1_val_q};
        acc_n       = sum_ext[ACC_WIDTH] ? '1 : sum_ext[ACC_WIDTH-1:0];
        cnt_n       = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        sat_n       = sat_q | s1_sat_q | sum_ext[ACC_WIDTH];
        err_n       = err_q | s1_err_q;
        fin         = s1_valid_q && s1_last_q;
        acc_d       = !s1_valid_q ? acc_q : fin ? '0 : acc_n;
        cnt_d       = !s1_valid_q ? cnt_q : fin ? '0 : cnt_n;
        sat_d       = !s1_valid_q ? sat_q : fin ? 1'b0 : sat_n;
        err_d       = !s1_valid_q ? err_q : fin ? 1'b0 : err_n;
        out_sum_d   = fin ? acc_n : out_sum_q;
        out_count_d = fin ? cnt_n : out_count_q;
        out_sat_d   = fin ? sat_n : out_sat_q;
        out_err_d   = fin ? err_n : out_err_q;
        state_d     = fin ? HOLD : (state_q == HOLD && out_ready_i) ? ACCUM : state_q;
    end

    // clear_i is a full flush, indistinguishable from reset
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= ACCUM;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_val_q    <= '0;
            s1_sat_q    <= 1'b0;
            s1_err_q    <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_val_q    <= s1_val_d;
            s1_sat_q    <= s1_sat_d;
            s1_err_q    <= s1_err_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            err_q       <= err_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
            out_err_q   <= out_err_d;
        end
    end
endmodule

// File: tb/tb_expu_accumulator.sv
// tb_expu_accumulator: scoreboard bench with a real-arithmetic row-sum reference model.
module tb_expu_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1, clear = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid, out_sat, out_err;
    logic [23:0] out_sum;
    logic [15:0] out_count;

    typedef struct {
        logic [23:0] sum;
        logic [15:0] cnt;
        logic        sat;
        logic        err;
    } res_t;

    res_t   exp_q[$];
    int     checks = 0, errors = 0;
    longint m_sum = 0;
    int     m_cnt = 0;
    bit     m_sat = 0, m_err = 0, rnd_ready = 0;

    expu_accumulator dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sum_o   (out_sum),
        .out_count_o (out_count),
        .out_sat_o   (out_sat),
        .out_err_o   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // value of an FP16ALT number times 2^16, by plain real arithmetic
    function automatic void conv(input logic [15:0] d, output longint v, output bit s, output bit e);
        int  ex = int'(d[14:7]);
        real r;
        v = 0; s = 0; e = 0;
        if (ex == 255 || (d[15] && ex != 0)) e = 1;
        else if (ex != 0) begin
            r = (128.0 + real'(d[6:0])) * $pow(2.0, real'(ex - 127 - 7 + 16));
            if (r >= 16777216.0) begin
                s = 1;
                v = 64'hFFFFFF;
            end else v = longint'($floor(r));
        end
    endfunction

    task automatic model_reset();
        m_sum = 0; m_cnt = 0; m_sat = 0; m_err = 0;
    endtask

    task automatic model_beat(input logic [15:0] d, input bit last);
        longint v;
        bit     s, e;
        res_t   r;
        conv(d, v, s, e);
        m_sum += v;
        if (m_sum > 64'hFFFFFF) begin
            m_sum = 64'hFFFFFF;
            m_sat = 1;
        end
        m_sat |= s;
        m_err |= e;
        if (m_cnt < 65535) m_cnt++;
        if (last) begin
            r.sum = m_sum[23:0]; r.cnt = m_cnt[15:0]; r.sat = m_sat; r.err = m_err;
            exp_q.push_back(r);
            model_reset();
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input bit last);
        int n = 0;
        in_valid = 1; in_data = d; in_last = last;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        model_beat(d, last);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("wait_valid", 64'(out_valid), 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", 64'(exp_q.size()), 0);
    endtask

    function automatic logic [15:0] rnd_fp();
        case ($urandom_range(0, 9))
            0:       return {1'b0, 8'h00, 7'($urandom)};
            1:       return {1'b1, 8'($urandom_range(1, 254)), 7'($urandom)};
            2:       return {1'($urandom), 8'hFF, 7'($urandom)};
            default: return {1'b0, 8'($urandom_range(105, 134)), 7'($urandom)};
        endcase
    endfunction

    // monitor: the handshake completes on the next rising edge
    initial forever begin
        res_t r;
        @(negedge clk);
        if (!rst && !clear && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                r = exp_q.pop_front();
                chk("sum", 64'(out_sum), 64'(r.sum));
                chk("count", 64'(out_count), 64'(r.cnt));
                chk("sat", 64'(out_sat), 64'(r.sat));
                chk("err", 64'(out_err), 64'(r.err));
            end
        end
    end

    initial forever begin
        @(posedge clk); #2;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_sum", 64'(out_sum), 0);
        chk("rst_count", 64'(out_count), 0);
        chk("rst_flags", 64'({out_sat, out_err}), 0);

        send_beat(16'h3F80, 0);
        send_beat(16'h3F00, 0);
        send_beat(16'h3E80, 1);
        chk("lat_t_valid", 64'(out_valid), 0);
        chk("lat_t_ready", 64'(in_ready), 0);
        @(posedge clk); #1;
        chk("lat_t1_valid", 64'(out_valid), 1);
        chk("lat_t1_ready", 64'(in_ready), 0);
        @(posedge clk); #1;
        chk("post_hs_ready", 64'(in_ready), 1);
        chk("post_hs_valid", 64'(out_valid), 0);

        send_beat(16'h3580, 0); send_beat(16'h0000, 1);
        send_beat(16'hBF80, 0); send_beat(16'h3F80, 1);
        send_beat(16'h7FC0, 1);
        send_beat(16'h4380, 1);
        send_beat(16'h4300, 0); send_beat(16'h4300, 1);
        drain();

        out_ready = 0;
        send_beat(16'h3F80, 0); send_beat(16'h4000, 1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(out_valid), 1);
            chk("bp_ready", 64'(in_ready), 0);
            chk("bp_sum", 64'(out_sum), 64'(exp_q[0].sum));
            chk("bp_count", 64'(out_count), 64'(exp_q[0].cnt));
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_ready", 64'(in_ready), 1);
        send_beat(16'h4040, 0); send_beat(16'h3F80, 1);
        drain();

        send_beat(16'h4000, 0); send_beat(16'h4000, 0);
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        model_reset();
        send_beat(16'h3F80, 1);
        drain();

        out_ready = 0;
        send_beat(16'h3F80, 1);
        wait_valid();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        exp_q.delete();
        chk("rst_hold_valid", 64'(out_valid), 0);
        chk("rst_hold_sum", 64'(out_sum), 0);
        chk("rst_hold_count", 64'(out_count), 0);
        chk("rst_hold_flags", 64'({out_sat, out_err}), 0);
        chk("rst_hold_ready", 64'(in_ready), 1);
        out_ready = 1;

        rnd_ready = 1;
        for (int r = 0; r < 30; r++) begin
            int len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) send_beat(rnd_fp(), b == len - 1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();
        rnd_ready = 0;
        out_ready = 1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
